// File: rtl/mdio_pkg.sv
// mdio_pkg: Clause 22 MDIO frame constants, FSM encoding and frame builder.
package mdio_pkg;
  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;
  localparam int MDIO_FRAME_LEN = 32;
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_FRAME, S_GAP} mdio_state_e;
  // Read frames pad TA/DATA with ones; those bits are never driven.
  function automatic logic [31:0] mdio_frame(input logic wr, input logic [4:0] phy,
                                             input logic [4:0] regad, input logic [15:0] wdata);
    return wr ? {MDIO_ST, MDIO_OP_WR, phy, regad, MDIO_TA_WR, wdata}
              : {MDIO_ST, MDIO_OP_RD, phy, regad, 18'h3FFFF};
  endfunction
endpackage

// File: rtl/mdio_clkgen.sv
// mdio_clkgen: MDC generator with one-cycle rise/fall strobes, held at 0 when disabled.
module mdio_clkgen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic rise,
  output logic fall
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
  logic [7:0] cnt_q, cnt_d;
  logic mdc_q, mdc_d, wrap;
  assign wrap = en && cnt_q == LAST;
  assign rise = wrap && !mdc_q;
  assign fall = wrap && mdc_q;
  assign mdc  = mdc_q;
  always_comb begin
    cnt_d = (!en || wrap) ? 8'd0 : cnt_q + 8'd1;
    mdc_d = en && (mdc_q ^ wrap);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end
endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause 22 MDIO master serialising host read/write commands onto MDC/MDIO.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 10,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        done,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        rd_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);
  localparam logic [5:0] PRE_LAST = 6'(PRE_LEN - 1);
  localparam logic [5:0] FRM_LAST = 6'(MDIO_FRAME_LEN - 1);
  mdio_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d, frame;
  logic [15:0] sh_q, sh_d, rd_data_q, rd_data_d;
  logic wr_q, wr_d, mdio_o_q, mdio_o_d, oe_q, oe_d, done_q, done_d;
  logic rd_valid_q, rd_valid_d, rd_err_q, rd_err_d, ta_q, ta_d;
  logic mdc_raw, rise, fall, accept;

  mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .mdc  (mdc_raw),
    .rise (rise),
    .fall (fall)
  );

  assign cmd_ready = state_q == S_IDLE;
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign frame     = mdio_frame(cmd_write, cmd_phy, cmd_reg, cmd_wdata);
  // The gap bit keeps the divider running for timing but holds MDC low.
  assign mdc       = mdc_raw && state_q != S_GAP;
  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = oe_q;
  assign done      = done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_err    = rd_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    wr_d       = wr_q;
    mdio_o_d   = mdio_o_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    sh_d       = sh_q;
    ta_d       = ta_q;
    if (accept) begin
      wr_d = cmd_write;
      oe_d = 1'b1;
      if (PRE_LEN > 0) begin
        state_d  = S_PRE;
        cnt_d    = PRE_LAST;
        sr_d     = frame;
        mdio_o_d = 1'b1;
      end else begin
        state_d  = S_FRAME;
        cnt_d    = FRM_LAST;
        sr_d     = {frame[30:0], 1'b0};
        mdio_o_d = frame[31];
      end
    end
    // cnt 16 is the second TA bit; cnt 15..0 are DATA bits.
    if (rise && state_q == S_FRAME && !wr_q) begin
      if (cnt_q == 6'd16) ta_d = mdio_i;
      if (cnt_q < 6'd16) sh_d = {sh_q[14:0], mdio_i};
    end
    if (fall) begin
      case (state_q)
        S_PRE: begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == '0) begin
            state_d  = S_FRAME;
            cnt_d    = FRM_LAST;
            mdio_o_d = sr_q[31];
            sr_d     = {sr_q[30:0], 1'b0};
          end
        end
        S_FRAME: begin
          if (cnt_q == '0) begin
            state_d  = S_GAP;
            mdio_o_d = 1'b1;
            oe_d     = 1'b0;
          end else begin
            cnt_d    = cnt_q - 6'd1;
            mdio_o_d = sr_q[31];
            sr_d     = {sr_q[30:0], 1'b0};
            oe_d     = wr_q || cnt_q > 6'd18;
          end
        end
        S_GAP: begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          rd_valid_d = !wr_q;
          rd_data_d  = wr_q ? rd_data_q : sh_q;
          rd_err_d   = wr_q ? rd_err_q : ta_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      wr_q       <= 1'b0;
      mdio_o_q   <= 1'b1;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      sh_q       <= '0;
      ta_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      wr_q       <= wr_d;
      mdio_o_q   <= mdio_o_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
      sh_q       <= sh_d;
      ta_q       <= ta_d;
    end
  end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed checks of frame bits, timing, reads, back-to-back and abort.
module tb_mdio_master;
  localparam int PA = 32;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_valid_b = 0, cmd_write = 0, mdio_i = 1;
  logic [4:0] cmd_phy = 0, cmd_reg = 0;
  logic [15:0] cmd_wdata = 0;
  logic cmd_ready, done, rd_valid, rd_err, busy, mdc, mdio_o, mdio_oe;
  logic [15:0] rd_data, rd_data_b;
  logic cmd_ready_b, done_b, rd_valid_b, rd_err_b, busy_b, mdc_b, mdio_o_b, mdio_oe_b;
  int total = 0, bad = 0;
  int n_done, hi, rdy, rv_early, nb;
  logic [63:0] cap, cap_oe;
  logic [31:0] cb;
  logic rv_done, pb;

  mdio_master #(.CLK_DIV(2), .PRE_LEN(32)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .done(done), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err), .busy(busy), .mdc(mdc), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  mdio_master #(.CLK_DIV(1), .PRE_LEN(0)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .done(done_b), .rd_valid(rd_valid_b),
    .rd_data(rd_data_b), .rd_err(rd_err_b), .busy(busy_b), .mdc(mdc_b), .mdio_o(mdio_o_b),
    .mdio_oe(mdio_oe_b), .mdio_i(1'b1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // PHY model: TA second bit 0, then data MSB first; mode 0 = absent PHY (pull-up).
  function automatic logic phy_bit(input int r, input int mode, input logic [15:0] d);
    int k;
    k = r - PA;
    if (mode == 0) return 1'b1;
    if (k == 15) return 1'b0;
    if (k >= 16 && k < 32) return d[31-k];
    return 1'b1;
  endfunction

  task automatic xact(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                      input logic [15:0] wd, input int mode, input logic [15:0] pd,
                      input logic hold, input int abort_at);
    logic prev;
    int r;
    cmd_write = wr; cmd_phy = phy; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1; mdio_i = 1;
    cap = 0; cap_oe = 0; hi = 0; rdy = 0; rv_early = 0; rv_done = 0; n_done = -1; r = 0; prev = 0;
    @(posedge clk); #1;
    if (!hold) begin
      cmd_valid = 0; cmd_phy = ~phy; cmd_reg = ~rg; cmd_wdata = ~wd; cmd_write = ~wr;
    end
    chk("start", {busy, cmd_ready, mdio_oe, mdio_o}, 4'b1011);
    for (int n = 1; n < 400; n++) begin
      if (done) begin
        n_done = n; rv_done = rd_valid;
        break;
      end
      if (abort_at != 0 && r == abort_at) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort", {mdc, mdio_oe, busy, cmd_ready, done}, 5'b00010);
        return;
      end
      hi += int'(mdc); rdy += int'(cmd_ready); rv_early += int'(rd_valid);
      if (mdc && !prev) begin
        cap = {cap[62:0], mdio_o}; cap_oe = {cap_oe[62:0], mdio_oe}; r++;
      end
      if (!mdc && prev) mdio_i = phy_bit(r, mode, pd);
      prev = mdc;
      @(posedge clk); #1;
    end
    if (n_done < 0) chk("timeout", done, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", {cmd_ready, busy, done, rd_valid, rd_err, mdc, mdio_o, mdio_oe}, 8'b10000010);
    chk("rst_a_data", rd_data, 0);
    chk("rst_b", {cmd_ready_b, busy_b, done_b, rd_valid_b, rd_err_b, mdc_b, mdio_o_b, mdio_oe_b}, 8'b10000010);
    rst = 0;
    xact(1, 5'd1, 5'd0, 16'h1234, 0, 0, 0, 0);
    chk("wr_cyc", n_done, 261);
    chk("wr_bits", cap, 64'hFFFFFFFF_50821234);
    chk("wr_oe", cap_oe, 64'hFFFFFFFF_FFFFFFFF);
    chk("wr_rv", {rv_done, 31'(rv_early)}, 0);
    chk("wr_mdc_hi", hi, 128);
    chk("wr_ready_busy", rdy, 0);
    xact(0, 5'd3, 5'd2, 16'h0, 1, 16'hBEEF, 0, 0);
    chk("rd_cyc", n_done, 261);
    chk("rd_bits", cap, 64'hFFFFFFFF_618BFFFF);
    chk("rd_oe", cap_oe, 64'hFFFFFFFF_FFFC0000);
    chk("rd_rv", rv_done, 1);
    chk("rd_data", rd_data, 16'hBEEF);
    chk("rd_err", rd_err, 0);
    xact(0, 5'd3, 5'd2, 16'h0, 0, 0, 0, 0);
    chk("abs_cyc", n_done, 261);
    chk("abs_data", {rd_valid, rd_err, rd_data}, {2'b11, 16'hFFFF});
    xact(1, 5'd7, 5'd9, 16'hCAFE, 0, 0, 1, 0);
    chk("b2b_wr_cyc", n_done, 261);
    chk("b2b_wr_bits", cap, 64'hFFFFFFFF_53A6CAFE);
    chk("b2b_ready_busy", rdy, 0);
    chk("b2b_rd_hold", {rd_err, rd_data}, {1'b1, 16'hFFFF});
    xact(0, 5'd7, 5'd9, 16'h0, 1, 16'h1357, 1, 0);
    cmd_valid = 0;
    chk("b2b_rd_cyc", n_done, 261);
    chk("b2b_rd_data", {rd_err, rd_data}, {1'b0, 16'h1357});
    chk("b2b_mdc_hi", hi, 128);
    @(posedge clk); #1;
    xact(1, 5'h15, 5'h0A, 16'h0F0F, 0, 0, 0, 38);
    xact(1, 5'd1, 5'd0, 16'h1234, 0, 0, 0, 0);
    chk("post_abort_cyc", n_done, 261);
    chk("post_abort_bits", cap, 64'hFFFFFFFF_50821234);
    @(posedge clk); #1;
    cmd_write = 1; cmd_phy = 5'd5; cmd_reg = 5'd31; cmd_wdata = 16'hA5C3; cmd_valid_b = 1;
    @(posedge clk); #1;
    cmd_valid_b = 0;
    chk("b_first", {mdio_o_b, mdio_oe_b, busy_b}, 3'b011);
    nb = -1; pb = 0; cb = 0;
    for (int n = 1; n < 200; n++) begin
      if (done_b) begin
        nb = n;
        break;
      end
      if (mdc_b && !pb) cb = {cb[30:0], mdio_o_b};
      pb = mdc_b;
      @(posedge clk); #1;
    end
    chk("b_cyc", nb, 67);
    chk("b_bits", cb, 32'h52FEA5C3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Parametrised IEEE 802.3 Clause 22 MDIO management master for the ethernet support core.
- Takes register read/write commands on a valid/ready host interface and serialises full MDIO frames on MDC/MDIO.
- Returns read data with a turnaround-error flag.
- Adds over the previous fixed-sequence MII block: configurable MDC divider and preamble length, host-selected PHY/register addressing, write and read support, and a completion handshake.

Parameters:
- CLK_DIV, 10, clk cycles per MDC half-period; legal range 1..255.
- PRE_LEN, 32, preamble bits (all ones) before ST; legal range 0..32; 0 = preamble suppression.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  master idle, accepts command
- cmd_write  input  1  1 = write frame, 0 = read frame
- cmd_phy  input  5  PHY address
- cmd_reg  input  5  register address
- cmd_wdata  input  16  write data; ignored for reads
- done  output  1  one-cycle pulse at end of any transaction
- rd_valid  output  1  one-cycle pulse with done, reads only
- rd_data  output  16  read result; held until the next read completes
- rd_err  output  1  TA second bit sampled as 1 (no PHY); valid with rd_valid
- busy  output  1  transaction in progress
- mdc  output  1  management clock
- mdio_o  output  1  MDIO drive value
- mdio_oe  output  1  MDIO output enable; the top level builds the tristate pad
- mdio_i  input  1  MDIO pad input

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - cmd_ready=1, busy=0, done=0, rd_valid=0, rd_data=0, rd_err=0.
  - mdc=0, mdio_o=1, mdio_oe=0.
- Accept: command is captured on any cycle where cmd_valid && cmd_ready. The next cycle has cmd_ready=0, busy=1, mdio_oe=1 and the first frame bit on mdio_o.
- Bit timing:
  - Each bit lasts 2*CLK_DIV cycles: mdc=0 for CLK_DIV cycles, then mdc=1 for CLK_DIV cycles.
  - mdio_o/mdio_oe change only in the cycle where mdc goes 1->0, or at frame start.
  - mdio_i is sampled in the cycle where mdc goes 0->1.
- Frame, MSB first:
  - PRE_LEN ones.
  - ST=01.
  - OP: 01 write, 10 read.
  - PHYAD[4:0], REGAD[4:0].
  - TA.
  - DATA[15:0].
- TA handling:
  - Write: TA=10, master drives all 32 post-preamble bits.
  - Read: mdio_oe=0 from the first TA bit through DATA bit 0.
  - Read: the second TA bit is sampled into rd_err.
  - Read: the 16 DATA bits are shifted into rd_data.
- Gap: after the last frame bit, one idle bit period (2*CLK_DIV cycles) follows with mdc=0, mdio_oe=0.
- FSM states: IDLE -> PRE (skipped if PRE_LEN=0) -> FRAME (32-bit counter) -> GAP -> IDLE.
- Completion:
  - done (and rd_valid for reads) pulses in cycle 1+2*CLK_DIV*(PRE_LEN+33) after accept.
  - In that same cycle busy=0 and cmd_ready=1.
- Back-to-back: a held cmd_valid is accepted in the done cycle. The next frame starts the following cycle.
- Input handling: cmd_* are sampled only at accept; changes during busy are ignored.
- Read data: rd_data/rd_err update only at read completion. A write does not disturb them.
- rst mid-frame: all state returns to reset values on the next edge (mdio_oe=0, mdc=0, busy=0). No done is produced.

Decomposition:
- Package mdio_pkg holds:
  - MDIO_ST=2'b01, MDIO_OP_WR=2'b01, MDIO_OP_RD=2'b10, MDIO_TA_WR=2'b10.
  - Frame length constant 32.
  - FSM state encoding.
- Sub-module mdio_clkgen:
  - CLK_DIV counter generating mdc plus one-cycle rise/fall strobes.
  - Enabled by busy; counter and mdc held at 0 when disabled.

Test Plan:
- CLK_DIV=2, PRE_LEN=32, write phy=1 reg=0 wdata=0x1234 -> mdio_o at each mdc rise is 32×1, then 01 01 00001 00000 10 0001001000110100; mdio_oe=1 throughout; done at cycle 261; rd_valid stays 0.
- Read phy=3 reg=2 with a PHY model that drives TA=Z0 and data 0xBEEF on mdc falls -> mdio_oe=0 for the last 18 bits; rd_valid at cycle 261; rd_data=0xBEEF, rd_err=0.
- Read with mdio_i tied 1 (absent PHY) -> rd_data=0xFFFF, rd_err=1, done still asserted at cycle 261.
- cmd_valid held high for two commands (write then read) -> cmd_ready=0 while busy; second accepted in the first done cycle; mdc low for exactly 2*CLK_DIV cycles between frames.
- PRE_LEN=0, CLK_DIV=1, write -> first bit is ST '0' in cycle 1; done at cycle 67.
- rst asserted in the middle of the PHYAD field -> next cycle mdc=0, mdio_oe=0, busy=0, cmd_ready=1; no done; a new command afterwards completes normally.
